// File: rtl/sticky_flag_bank_if.sv
// Bus bundle for sticky_flag_bank: raw request/hold lines in, flag/pulse/counter
// status out. master drives the requests, slave is the flag bank itself.
interface sticky_flag_bank_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 8
);
    logic [CH-1:0]       set_b_n;
    logic [CH-1:0]       set_c_n;
    logic [CH-1:0]       hold;
    logic                cnt_clr;
    logic [CH-1:0]       flag;
    logic [CH-1:0]       rise;
    logic                any_flag;
    logic [CH*CNT_W-1:0] set_cnt;

    modport master (
        output set_b_n, set_c_n, hold, cnt_clr,
        input  flag, rise, any_flag, set_cnt
    );

    modport slave (
        input  set_b_n, set_c_n, hold, cnt_clr,
        output flag, rise, any_flag, set_cnt
    );
endinterface

// File: rtl/sticky_flag_bank.sv
// Bank of CH sticky flags fed by asynchronous active-low set requests and a hold
// line, with per-channel rise pulses and saturating event counters.
module sticky_flag_bank #(
    parameter int CH          = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SET_PRIO    = 1,
    parameter int FLAG_INIT   = 1
) (
    input logic            clk,
    input logic            rst_n,
    sticky_flag_bank_if.slave bus
);

    typedef enum logic {LO = 1'b0, HI = 1'b1} state_t;

    logic [SYNC_STAGES-1:0][CH-1:0] b_sync_p0;
    logic [SYNC_STAGES-1:0][CH-1:0] c_sync_p0;
    logic [SYNC_STAGES-1:0][CH-1:0] hold_sync_p0;

    logic [CH-1:0] set_req;
    logic [CH-1:0] clr_req;
    logic [CH-1:0] set_go;
    logic [CH-1:0] clr_go;

    state_t             state_p1 [CH];
    logic [CH-1:0]      rise_p1;
    logic [CNT_W-1:0]   cnt_p1   [CH];
    logic [CH-1:0]      flag_vec;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Synchroniser stage: reset to the inactive level so leaving reset neither sets nor clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_sync_p0    <= '1;
            c_sync_p0    <= '1;
            hold_sync_p0 <= '1;
        end else begin
            b_sync_p0    <= {b_sync_p0[SYNC_STAGES-2:0], bus.set_b_n};
            c_sync_p0    <= {c_sync_p0[SYNC_STAGES-2:0], bus.set_c_n};
            hold_sync_p0 <= {hold_sync_p0[SYNC_STAGES-2:0], bus.hold};
        end
    end

    always_comb begin
        set_req = ~b_sync_p0[SYNC_STAGES-1] | ~c_sync_p0[SYNC_STAGES-1];
        clr_req = ~hold_sync_p0[SYNC_STAGES-1];
        set_go  = '0;
        clr_go  = '0;
        for (int i = 0; i < CH; i++) begin
            set_go[i] = (state_p1[i] == LO) && set_req[i] && ((SET_PRIO != 0) || !clr_req[i]);
            clr_go[i] = (state_p1[i] == HI) && clr_req[i] && ((SET_PRIO == 0) || !set_req[i]);
        end
    end

    // Flag stage: per-channel LO/HI machine, rise pulse and counter share the set edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                state_p1[i] <= (FLAG_INIT != 0) ? HI : LO;
                cnt_p1[i]   <= '0;
            end
            rise_p1 <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                case (state_p1[i])
                    LO: if (set_go[i]) state_p1[i] <= HI;
                    HI: if (clr_go[i]) state_p1[i] <= LO;
                    default: state_p1[i] <= LO;
                endcase
                rise_p1[i] <= set_go[i];
                if (bus.cnt_clr)
                    cnt_p1[i] <= {{(CNT_W-1){1'b0}}, set_go[i]};
                else if (set_go[i])
                    cnt_p1[i] <= sat_inc(cnt_p1[i]);
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_out
        assign flag_vec[g]                       = (state_p1[g] == HI);
        assign bus.set_cnt[g*CNT_W +: CNT_W]     = cnt_p1[g];
    end

    assign bus.flag     = flag_vec;
    assign bus.rise     = rise_p1;
    assign bus.any_flag = |flag_vec;

endmodule
